dadda_check_responder: RTL

Hardware responder for the 16×16 Dadda multiplier on the Nexys4 DDR build: it accepts operand pairs over a valid/ready handshake, drives them into an internal `dadda_mul` instance, and returns the registered product. It also returns a golden product from an iterative shift-add multiplier, a match flag and running pass/error counters. It is the on-chip counterpart of the file-driven stimulus bench, so the multiplier can be checked on the board and not only in simulation.

---
 rtl/dadda_check_responder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dadda_check_responder.sv
// dadda_check_responder: valid/ready wrapper around a 16x16 Dadda multiplier with optional
// on-chip shift-add golden check, built when DADDA_CHECK_EN is defined.

module dadda_mul #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    localparam int PW = 2 * WIDTH;

    // Dadda row-height sequence for a 16-row partial-product matrix.
    function automatic int height(input int s);
        case (s)
            0:       return 16;
            1:       return 13;
            2:       return 9;
            3:       return 6;
            4:       return 4;
            5:       return 3;
            default: return 2;
        endcase
    endfunction

    logic [PW-1:0] rows [7][16];

    always_comb begin
        rows = '{default: '{default: '0}};
        for (int i = 0; i < WIDTH; i++) begin
            rows[0][i] = b[i] ? (PW'(a) << i) : '0;
        end
        // Each stage uses just enough 3:2 compressors to reach the next height;
        // untouched rows pass straight through behind the compressor outputs.
        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < 5; j++) begin
                if (j < height(s) - height(s + 1)) begin
                    rows[s+1][2*j]   = rows[s][3*j] ^ rows[s][3*j+1] ^ rows[s][3*j+2];
                    rows[s+1][2*j+1] = ((rows[s][3*j] & rows[s][3*j+1]) |
                                        (rows[s][3*j] & rows[s][3*j+2]) |
                                        (rows[s][3*j+1] & rows[s][3*j+2])) << 1;
                end
            end
            for (int i = 0; i < 16; i++) begin
                if (i >= 3 * (height(s) - height(s + 1)) && i < height(s)) begin
                    rows[s+1][i-(height(s)-height(s+1))] = rows[s][i];
                end
            end
        end
    end

    assign p = rows[6][0] + rows[6][1];
endmodule

module dadda_check_responder #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [2*WIDTH-1:0]   out_expected,
    output logic                 out_match,
    output logic [CNT_W-1:0]     pair_count,
    output logic [CNT_W-1:0]     err_count
);
    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    prod_q, prod_d, exp_q, exp_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] pair_q, pair_d, err_q, err_d;
    logic [PW-1:0]    dadda_prod;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             in_fire, out_fire;

`ifdef DADDA_CHECK_EN
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d, acc_next;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic             last_bit;

    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign acc_next = acc_q + (b_q[bit_idx_q] ? (PW'(a_q) << bit_idx_q) : '0);
    assign last_bit = (bit_idx_q == IW'(WIDTH - 1));
`else
    // Without the checker the multiplier sees the operands on the accept edge directly.
    assign mul_a = in_a;
    assign mul_b = in_b;
`endif

    dadda_mul #(.WIDTH(WIDTH)) u_dadda (
        .a (mul_a),
        .b (mul_b),
        .p (dadda_prod)
    );

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef DADDA_CHECK_EN
            IDLE:    if (in_fire) state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
`else
            IDLE:    if (in_fire) state_d = DONE;
`endif
            DONE:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        prod_d  = prod_q;
        exp_d   = exp_q;
        match_d = match_q;
        pair_d  = pair_q;
        err_d   = err_q;
`ifdef DADDA_CHECK_EN
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        if (state_q == IDLE && in_fire) begin
            a_d       = in_a;
            b_d       = in_b;
            acc_d     = '0;
            bit_idx_d = '0;
        end
        if (state_q == CALC) begin
            acc_d     = acc_next;
            bit_idx_d = bit_idx_q + 1'b1;
            if (last_bit) begin
                prod_d  = dadda_prod;
                exp_d   = acc_next;
                match_d = (dadda_prod == acc_next);
            end
        end
`else
        if (state_q == IDLE && in_fire) begin
            prod_d  = dadda_prod;
            exp_d   = dadda_prod;
            match_d = 1'b1;
        end
`endif
        if (state_q == DONE && out_fire) begin
            pair_d = pair_q + 1'b1;
            if (!match_q && err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            pair_q  <= '0;
            err_q   <= '0;
`ifdef DADDA_CHECK_EN
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            bit_idx_q <= '0;
`endif
        end else begin
            prod_q  <= prod_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            pair_q  <= pair_d;
            err_q   <= err_d;
`ifdef DADDA_CHECK_EN
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
`endif
        end
    end

    assign out_product  = prod_q;
    assign out_expected = exp_q;
    assign out_match    = match_q;
    assign pair_count   = pair_q;
    assign err_count    = err_q;
endmodule
